// File: rtl/zbus_iosel_pkg.sv
// Shared types and helpers for the ZX-bus I/O access sequencer.
package zbus_iosel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    WAITEND
  } state_t;

  // Channel k occupies bits [16k+15:16k] of a packed mask/base vector.
  function automatic logic [15:0] slice16(input logic [127:0] vec, input int unsigned k);
    return vec[16*k +: 16];
  endfunction

  function automatic int unsigned cnt_width(input int unsigned s, input int unsigned p,
                                            input int unsigned h);
    int unsigned m;
    m = s;
    if (p > m) m = p;
    if (h > m) m = h;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/zbus_iosel_seq_if.sv
// ZX-bus side and chip side signals of the I/O access sequencer.
interface zbus_iosel_seq_if #(
  parameter int unsigned NCH = 2
);
  logic [15:0]    za;
  logic           ziorq_n;
  logic           zrd_n;
  logic           zwr_n;
  logic [NCH-1:0] chan_en;
  logic [NCH-1:0] cs_n;
  logic           bstb_rd_n;
  logic           bstb_wr_n;
  logic           ziorqge;
  logic           rd_latch;
  logic           busy;
  logic [15:0]    stat_cnt;

  modport master (
    output za, ziorq_n, zrd_n, zwr_n, chan_en,
    input  cs_n, bstb_rd_n, bstb_wr_n, ziorqge, rd_latch, busy, stat_cnt
  );

  modport slave (
    input  za, ziorq_n, zrd_n, zwr_n, chan_en,
    output cs_n, bstb_rd_n, bstb_wr_n, ziorqge, rd_latch, busy, stat_cnt
  );
endinterface

// File: rtl/zbus_sync_bit.sv
// Multi-flop synchroniser for one asynchronous active-low bus signal; resets to 1.
module zbus_sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic fclk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge fclk) begin
    if (rst) chain <= '1;
    else     chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];
endmodule

// File: rtl/zbus_iosel_seq.sv
// ZX-bus I/O access sequencer: decodes IORQ windows, drives chip selects and timed RD/WR strobes.
// Optional completed-access counter on stat_cnt enabled by `define ZBUS_IOSEL_STATS_EN.
module zbus_iosel_seq
  import zbus_iosel_pkg::*;
#(
  parameter int unsigned          NCH         = 2,
  parameter logic [16*NCH-1:0]    ADDR_MASK   = {16'hFF00, 16'hFFFE},
  parameter logic [16*NCH-1:0]    ADDR_BASE   = {16'hAB00, 16'h00F4},
  parameter int unsigned          SETUP_CYC   = 1,
  parameter int unsigned          PULSE_CYC   = 3,
  parameter int unsigned          HOLD_CYC    = 1,
  parameter int unsigned          SYNC_STAGES = 2
) (
  input  logic             fclk,
  input  logic             rst,
  zbus_iosel_seq_if.slave  bus
);
  localparam int unsigned   CW       = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam logic [127:0]  MASK_W   = 128'(ADDR_MASK);
  localparam logic [127:0]  BASE_W   = 128'(ADDR_BASE);
  localparam logic [CW-1:0] LD_SETUP = CW'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CW-1:0] LD_PULSE = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  logic iorq_q, rd_q, wr_q;
  logic s_iorq, s_rd, s_wr;

  zbus_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_iorq (
    .fclk(fclk), .rst(rst), .d(bus.ziorq_n), .q(iorq_q));
  zbus_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
    .fclk(fclk), .rst(rst), .d(bus.zrd_n), .q(rd_q));
  zbus_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
    .fclk(fclk), .rst(rst), .d(bus.zwr_n), .q(wr_q));

  assign s_iorq = !iorq_q;
  assign s_rd   = !rd_q;
  assign s_wr   = !wr_q;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [NCH-1:0] sel_oh, sel_nxt;
  logic           dir_rd, dir_nxt;
  logic           hit_q, hit_nxt;
  logic           armed;
  logic [NCH-1:0] hit_vec, hit_first;
  logic           start;

  always_comb begin
    hit_vec = '0;
    for (int unsigned k = 0; k < NCH; k++)
      hit_vec[k] = bus.chan_en[k] && ((bus.za & slice16(MASK_W, k)) == slice16(BASE_W, k));
  end

  // Isolate the lowest set bit so the lowest-index channel wins on overlap.
  assign hit_first = hit_vec & (~hit_vec + NCH'(1));
  assign start     = (state == IDLE) && armed && s_iorq && (s_rd ^ s_wr);

  always_ff @(posedge fclk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      sel_oh <= '0;
      dir_rd <= 1'b0;
      hit_q  <= 1'b0;
      armed  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      sel_oh <= sel_nxt;
      dir_rd <= dir_nxt;
      hit_q  <= hit_nxt;
      armed  <= (state == IDLE) && (state_nxt == IDLE) && (armed || !s_iorq);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel_oh;
    dir_nxt   = dir_rd;
    hit_nxt   = hit_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          dir_nxt = s_rd;
          sel_nxt = hit_first;
          hit_nxt = |hit_vec;
          if (!(|hit_vec)) begin
            state_nxt = WAITEND;
          end else if (SETUP_CYC > 0) begin
            state_nxt = SETUP;
            cnt_nxt   = LD_SETUP;
          end else begin
            state_nxt = STROBE;
            cnt_nxt   = LD_PULSE;
          end
        end
      end
      SETUP: begin
        if (!s_iorq) begin
          state_nxt = WAITEND;
        end else if (cnt == '0) begin
          state_nxt = STROBE;
          cnt_nxt   = LD_PULSE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      STROBE: begin
        if (!s_iorq || cnt == '0) begin
          if (HOLD_CYC > 0) begin
            state_nxt = HOLD;
            cnt_nxt   = LD_HOLD;
          end else begin
            state_nxt = WAITEND;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) state_nxt = WAITEND;
        else           cnt_nxt   = cnt - CW'(1);
      end
      WAITEND: begin
        if (!s_iorq) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  logic [NCH-1:0] cs_d, cs_q;
  logic           rd_d, rd_q2, wr_d, wr_q2, ge_d, ge_q, latch_d, latch_q;

  always_comb begin
    cs_d    = '1;
    rd_d    = 1'b1;
    wr_d    = 1'b1;
    ge_d    = 1'b0;
    latch_d = 1'b0;
    unique case (state_nxt)
      SETUP, HOLD: begin
        cs_d = ~sel_nxt;
        ge_d = 1'b1;
      end
      STROBE: begin
        cs_d    = ~sel_nxt;
        ge_d    = 1'b1;
        rd_d    = !dir_nxt;
        wr_d    = dir_nxt;
        latch_d = dir_nxt && (cnt_nxt == '0);
      end
      WAITEND: ge_d = hit_nxt;
      default: ;
    endcase
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      cs_q    <= '1;
      rd_q2   <= 1'b1;
      wr_q2   <= 1'b1;
      ge_q    <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      cs_q    <= cs_d;
      rd_q2   <= rd_d;
      wr_q2   <= wr_d;
      ge_q    <= ge_d;
      latch_q <= latch_d;
    end
  end

  assign bus.cs_n      = cs_q;
  assign bus.bstb_rd_n = rd_q2;
  assign bus.bstb_wr_n = wr_q2;
  assign bus.ziorqge   = ge_q;
  assign bus.rd_latch  = latch_q;
  assign bus.busy      = (state != IDLE);

`ifdef ZBUS_IOSEL_STATS_EN
  logic [15:0] stat_q;

  always_ff @(posedge fclk) begin
    if (rst)
      stat_q <= '0;
    else if (state == STROBE && state_nxt != STROBE && stat_q != '1)
      stat_q <= stat_q + 16'd1;
  end

  assign bus.stat_cnt = stat_q;
`else
  assign bus.stat_cnt = '0;
`endif

endmodule
